// File: rtl/hbm_traffic_write.sv
// hbm_traffic_write: AXI write traffic generator issuing strided bursts to one HBM pseudo-channel.
// Define HBM_WRITE_PATTERN_EN to send {burst, beat} indexed write data instead of zeros.
module hbm_traffic_write #(
    parameter int ENGINE_ID       = 0,
    parameter int ADDR_WIDTH      = 33,
    parameter int DATA_WIDTH      = 256,
    parameter int ID_WIDTH        = 5,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_write,
    input  logic [31:0]             write_ops,
    input  logic [31:0]             stride,
    input  logic [ADDR_WIDTH-1:0]   init_addr,
    input  logic [15:0]             mem_burst_size,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_cnt,
    output logic                    m_axi_AWVALID,
    input  logic                    m_axi_AWREADY,
    output logic [ADDR_WIDTH-1:0]   m_axi_AWADDR,
    output logic [ID_WIDTH-1:0]     m_axi_AWID,
    output logic [7:0]              m_axi_AWLEN,
    output logic [2:0]              m_axi_AWSIZE,
    output logic [1:0]              m_axi_AWBURST,
    output logic [1:0]              m_axi_AWLOCK,
    output logic [3:0]              m_axi_AWCACHE,
    output logic [2:0]              m_axi_AWPROT,
    output logic [3:0]              m_axi_AWQOS,
    output logic [3:0]              m_axi_AWREGION,
    output logic                    m_axi_WVALID,
    input  logic                    m_axi_WREADY,
    output logic [DATA_WIDTH-1:0]   m_axi_WDATA,
    output logic [DATA_WIDTH/8-1:0] m_axi_WSTRB,
    output logic                    m_axi_WLAST,
    output logic [ID_WIDTH-1:0]     m_axi_WID,
    input  logic                    m_axi_BVALID,
    input  logic [1:0]              m_axi_BRESP,
    input  logic [ID_WIDTH-1:0]     m_axi_BID,
    output logic                    m_axi_BREADY
);
    localparam int SHIFT = (DATA_WIDTH == 512) ? 6 : 5;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [31:0] ops, stride_r, aw_cnt, w_cnt, b_cnt;
    logic [15:0] bsize;
    logic [7:0] beat;
    logic [ADDR_WIDTH-1:0] addr;
    logic launch, aw_hs, w_hs, b_hs;
    logic unused_ok;
    assign unused_ok = ^{init_addr[ADDR_WIDTH-1:28], m_axi_BID};
    assign m_axi_AWID     = '0;
    assign m_axi_WID      = '0;
    assign m_axi_AWSIZE   = (DATA_WIDTH == 512) ? 3'b110 : 3'b101;
    assign m_axi_AWBURST  = 2'b01;
    assign m_axi_AWLOCK   = 2'b00;
    assign m_axi_AWCACHE  = 4'h0;
    assign m_axi_AWPROT   = 3'b010;
    assign m_axi_AWQOS    = 4'h0;
    assign m_axi_AWREGION = 4'h0;
    assign m_axi_WSTRB    = '1;
    assign m_axi_BREADY   = 1'b1;
    assign m_axi_AWLEN    = 8'((bsize >> SHIFT) - 16'd1);
    assign m_axi_AWADDR   = addr;
`ifdef HBM_WRITE_PATTERN_EN
    assign m_axi_WDATA = {(DATA_WIDTH/32){w_cnt[15:0], 8'd0, beat}};
`else
    assign m_axi_WDATA = '0;
`endif
    // Outstanding window can only shrink while AWVALID waits, so AWVALID never drops unaccepted.
    assign m_axi_AWVALID = (state == RUN) && (aw_cnt < ops) && ((aw_cnt - b_cnt) < 32'(MAX_OUTSTANDING));
    assign m_axi_WVALID  = (state == RUN) && (w_cnt < aw_cnt);
    assign m_axi_WLAST   = m_axi_WVALID && (beat == m_axi_AWLEN);
    assign busy   = (state != IDLE);
    assign done   = (state == DRAIN) && (b_cnt == ops);
    assign launch = (state == IDLE) && start_write;
    assign aw_hs  = m_axi_AWVALID && m_axi_AWREADY;
    assign w_hs   = m_axi_WVALID && m_axi_WREADY;
    assign b_hs   = m_axi_BVALID && busy;
    always_comb begin
        state_nx = state;
        state_nx = launch ? RUN
                 : (state == RUN && aw_cnt == ops && w_cnt == ops) ? DRAIN
                 : done ? IDLE
                 : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ops      <= '0;
            stride_r <= '0;
            bsize    <= '0;
            addr     <= '0;
            aw_cnt   <= '0;
            w_cnt    <= '0;
            b_cnt    <= '0;
            beat     <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                ops      <= write_ops;
                stride_r <= stride;
                bsize    <= mem_burst_size;
                addr     <= ADDR_WIDTH'({4'(ENGINE_ID), init_addr[27:0]});
                aw_cnt   <= '0;
                w_cnt    <= '0;
                b_cnt    <= '0;
                beat     <= '0;
                err_cnt  <= '0;
            end else begin
                if (aw_hs) begin
                    aw_cnt <= aw_cnt + 32'd1;
                    addr   <= addr + ADDR_WIDTH'(stride_r);
                end
                if (w_hs) begin
                    beat  <= m_axi_WLAST ? 8'd0 : beat + 8'd1;
                    w_cnt <= m_axi_WLAST ? w_cnt + 32'd1 : w_cnt;
                end
                if (b_hs) begin
                    b_cnt   <= b_cnt + 32'd1;
                    err_cnt <= (m_axi_BRESP != 2'b00 && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
                end
            end
        end
    end
endmodule
